// File: rtl/gpu_pkg.sv
// Shared GPU definitions: default datapath widths and the primitive assembler state encoding.
package gpu_pkg;

  localparam int FIXED_WIDTH_DEFAULT = 16;
  localparam int INDEX_BIT_DEFAULT   = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH0 = 3'd1,
    S_FETCH1 = 3'd2,
    S_FETCH2 = 3'd3,
    S_OUT    = 3'd4,
    S_DONE   = 3'd5
  } pa_state_e;

endpackage

// File: rtl/vertex_2d_ram.sv
// Screen-space vertex store: one (slot, component) write port and one combinational
// read port returning the packed {x, y} pair of a slot.
module vertex_2d_ram
  import gpu_pkg::*;
#(
  parameter int FIXED_WIDTH = FIXED_WIDTH_DEFAULT,
  parameter int INDEX_BIT   = INDEX_BIT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [INDEX_BIT-1:0]     wr_slot,
  input  logic                     wr_comp,
  input  logic [FIXED_WIDTH-1:0]   wr_data,
  input  logic [INDEX_BIT-1:0]     rd_slot,
  output logic [2*FIXED_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << INDEX_BIT;

  logic [FIXED_WIDTH-1:0] mem_x [DEPTH];
  logic [FIXED_WIDTH-1:0] mem_y [DEPTH];

  // NOTE: storage has no reset so it maps onto plain RAM; every slot is written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_comp) mem_y[wr_slot] <= wr_data;
      else         mem_x[wr_slot] <= wr_data;
    end
  end

  assign rd_data = {mem_x[rd_slot], mem_y[rd_slot]};

endmodule

// File: rtl/prim_assembler.sv
// Primitive assembler: buffers 2D vertices from the vertex shader, then emits
// consecutive vertex triples as triangles over a valid/ready handshake.
module prim_assembler
  import gpu_pkg::*;
#(
  parameter int FIXED_WIDTH = FIXED_WIDTH_DEFAULT,
  parameter int INDEX_BIT   = INDEX_BIT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FIXED_WIDTH-1:0] vs_2d_vertex_data,
  input  logic [INDEX_BIT-1:0]   vs_2d_vertex_index,
  input  logic                   vs_2d_vertex_comp,
  input  logic                   vs_2d_vertex_wr,
  input  logic                   vs_2d_done,
  input  logic [INDEX_BIT-1:0]   num_vertex_in,
  output logic                   pa_busy,
  output logic                   tri_valid,
  input  logic                   tri_ready,
  output logic [FIXED_WIDTH-1:0] tri_x0,
  output logic [FIXED_WIDTH-1:0] tri_y0,
  output logic [FIXED_WIDTH-1:0] tri_x1,
  output logic [FIXED_WIDTH-1:0] tri_y1,
  output logic [FIXED_WIDTH-1:0] tri_x2,
  output logic [FIXED_WIDTH-1:0] tri_y2,
  output logic [INDEX_BIT-1:0]   tri_id,
  output logic                   frame_done,
  output logic                   wr_drop
);

  pa_state_e                state, state_nxt;
  logic [INDEX_BIT-1:0]     tri_total, base, rd_slot, done_total;
  logic [2*FIXED_WIDTH-1:0] rd_data;
  logic [FIXED_WIDTH-1:0]   rd_x, rd_y;
  logic                     wr_accept, last_tri;

  assign wr_accept  = vs_2d_vertex_wr && (state == S_IDLE);
  assign done_total = INDEX_BIT'(32'(num_vertex_in) / 32'd3);
  assign last_tri   = (tri_id == tri_total - INDEX_BIT'(1));
  assign rd_x       = rd_data[2*FIXED_WIDTH-1:FIXED_WIDTH];
  assign rd_y       = rd_data[FIXED_WIDTH-1:0];

  vertex_2d_ram #(
    .FIXED_WIDTH(FIXED_WIDTH),
    .INDEX_BIT  (INDEX_BIT)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_accept),
    .wr_slot(vs_2d_vertex_index),
    .wr_comp(vs_2d_vertex_comp),
    .wr_data(vs_2d_vertex_data),
    .rd_slot(rd_slot),
    .rd_data(rd_data)
  );

  // The fetch state selects which vertex of the current triangle is read.
  always_comb begin
    case (state)
      S_FETCH1: rd_slot = base + INDEX_BIT'(1);
      S_FETCH2: rd_slot = base + INDEX_BIT'(2);
      default:  rd_slot = base;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt takes a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (vs_2d_done) state_nxt = (done_total != '0) ? S_FETCH0 : S_DONE;
      end
      S_FETCH0: state_nxt = S_FETCH1;
      S_FETCH1: state_nxt = S_FETCH2;
      S_FETCH2: state_nxt = S_OUT;
      S_OUT: begin
        if (tri_ready) state_nxt = last_tri ? S_DONE : S_FETCH0;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pa_busy   = (state != S_IDLE);
    tri_valid = (state == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tri_total  <= '0;
      base       <= '0;
      tri_id     <= '0;
      frame_done <= 1'b0;
      wr_drop    <= 1'b0;
      tri_x0     <= '0;
      tri_y0     <= '0;
      tri_x1     <= '0;
      tri_y1     <= '0;
      tri_x2     <= '0;
      tri_y2     <= '0;
    end else begin
      wr_drop    <= vs_2d_vertex_wr && (state != S_IDLE);
      frame_done <= (state == S_DONE);
      if (state == S_IDLE && vs_2d_done) begin
        tri_total <= done_total;
        base      <= '0;
        tri_id    <= '0;
      end
      if (state == S_OUT && tri_ready && !last_tri) begin
        base   <= base + INDEX_BIT'(3);
        tri_id <= tri_id + INDEX_BIT'(1);
      end
      // Triangle registers change only while fetching, so they hold through S_OUT stalls.
      case (state)
        S_FETCH0: begin tri_x0 <= rd_x; tri_y0 <= rd_y; end
        S_FETCH1: begin tri_x1 <= rd_x; tri_y1 <= rd_y; end
        S_FETCH2: begin tri_x2 <= rd_x; tri_y2 <= rd_y; end
        default: ;
      endcase
    end
  end

endmodule
